// File: rtl/riscv_pkg.sv
// Shared RV32 load/store constants: funct3 size codes, LSU FSM encoding, byte-lane masks.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_MEM  = 1'b1;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half lane of a memory word and sign- or zero-extends it.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_off, 3'b000} +: 8];
        w_half = i_rdata[{i_off[1], 4'b0000} +: 16];
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'h0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'h0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Two-state load/store unit: pass-through, alignment/legality checks, one word-aligned access.
module load_store_unit
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        lsu_err
);

    logic        r_state;
    logic        r_mem_en;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_we;
    logic [31:0] r_mem_wdata;
    logic        r_is_load;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_wb_valid;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_rd;
    logic        r_lsu_err;

    logic        w_is_mem;
    logic        w_bad;
    logic        w_accept;
    logic [3:0]  w_st_mask;
    logic [31:0] w_st_wdata;
    logic [31:0] w_load_data;

    assign w_is_mem = req_load || req_store;
    assign w_bad    = f3_illegal(req_funct3) || f3_misaligned(req_funct3, req_addr[1:0]);
    assign w_accept = (r_state == ST_IDLE) && req_valid && w_is_mem && !w_bad;

    assign stall = (r_state == ST_MEM) || w_accept;

    // Store lanes: the narrow datum is replicated so the byte mask alone selects it.
    always_comb begin
        w_st_mask  = MASK_W;
        w_st_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_st_mask  = MASK_B << req_addr[1:0];
                w_st_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_st_mask  = MASK_H << {req_addr[1], 1'b0};
                w_st_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_st_mask  = MASK_W;
                w_st_wdata = req_wdata;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .i_rdata  (mem_rdata),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_we    <= 4'h0;
            r_mem_wdata <= 32'h0;
            r_is_load   <= 1'b0;
            r_rd        <= 5'h0;
            r_funct3    <= 3'h0;
            r_off       <= 2'h0;
            r_wb_valid  <= 1'b0;
            r_wb_data   <= 32'h0;
            r_wb_rd     <= 5'h0;
            r_lsu_err   <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_lsu_err  <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (req_valid && !w_is_mem) begin
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= req_addr;
                    r_wb_rd    <= req_rd;
                end else if (req_valid && w_bad) begin
                    r_lsu_err <= 1'b1;
                end else if (w_accept) begin
                    r_state     <= ST_MEM;
                    r_mem_en    <= 1'b1;
                    r_mem_addr  <= {req_addr[31:2], 2'b00};
                    r_mem_we    <= req_load ? 4'h0 : w_st_mask;
                    r_mem_wdata <= w_st_wdata;
                    r_is_load   <= req_load;
                    r_rd        <= req_rd;
                    r_funct3    <= req_funct3;
                    r_off       <= req_addr[1:0];
                end
            end else if (mem_ready) begin
                r_state  <= ST_IDLE;
                r_mem_en <= 1'b0;
                r_mem_we <= 4'h0;
                if (r_is_load) begin
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= w_load_data;
                    r_wb_rd    <= r_rd;
                end
            end
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign wb_valid  = r_wb_valid;
    assign wb_data   = r_wb_data;
    assign wb_rd     = r_wb_rd;
    assign lsu_err   = r_lsu_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized requests against a byte-level model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        req_load;
    logic        req_store;
    logic [4:0]  req_rd;
    logic        stall;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        lsu_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_rd     (req_rd),
        .stall      (stall),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .lsu_err    (lsu_err)
    );

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_bad(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        return (a % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = ((1 << size_of(f3)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        longint r;
        int sz;
        sz = size_of(f3);
        r = 0;
        for (int i = 0; i < 4; i++)
            r = r | (((longint'(wd) >> (8 * (i % sz))) & 64'hFF) << (8 * i));
        return r[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        longint v;
        int sz;
        sz = size_of(f3);
        v = (longint'(rdata) >> (8 * (a % 4))) & ((64'd1 << (8 * sz)) - 1);
        if (f3[2] == 1'b0 && sz < 4 && ((v >> (8 * sz - 1)) & 1) == 1)
            v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    // Drives one request starting just after a rising edge and follows it to completion.
    task automatic run_op(input string nm, input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdata, input int lat,
                          output logic [31:0] c_addr, output logic [3:0] c_we,
                          output logic [31:0] c_wdata, output logic [31:0] c_wb);
        bit is_mem, bad;
        logic [31:0] e_addr, e_load;
        logic [3:0]  e_we;
        is_mem = ld || st;
        bad    = is_mem && model_bad(f3, a);
        e_addr = {a[31:2], 2'b00};
        e_we   = ld ? 4'h0 : model_mask(f3, a);
        e_load = model_load(f3, a, rdata);
        req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd; req_rd = rd;
        mem_ready = 1'($urandom);
        #1;
        n_chk++;
        if (stall !== (is_mem && !bad))
            $display("FAIL %s stall_req: got %0b want %0b", nm, stall, is_mem && !bad);
        else n_pass++;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        req_valid = 1'b0;
        c_addr = mem_addr; c_we = mem_we; c_wdata = mem_wdata; c_wb = wb_data;
        if (!is_mem) begin
            n_chk++;
            if (wb_valid !== 1'b1 || wb_data !== a || wb_rd !== rd || lsu_err !== 1'b0
                || mem_en !== 1'b0)
                $display("FAIL %s pass: got v=%0b d=%h rd=%0d err=%0b en=%0b want 1 %h %0d 0 0",
                         nm, wb_valid, wb_data, wb_rd, lsu_err, mem_en, a, rd);
            else n_pass++;
        end else if (bad) begin
            n_chk++;
            if (lsu_err !== 1'b1 || wb_valid !== 1'b0 || mem_en !== 1'b0)
                $display("FAIL %s err: got err=%0b v=%0b en=%0b want 1 0 0",
                         nm, lsu_err, wb_valid, mem_en);
            else n_pass++;
        end else begin
            n_chk++;
            if (mem_en !== 1'b1 || mem_addr !== e_addr || mem_we !== e_we || stall !== 1'b1
                || wb_valid !== 1'b0)
                $display("FAIL %s issue: got en=%0b a=%h we=%b st=%0b v=%0b want 1 %h %b 1 0",
                         nm, mem_en, mem_addr, mem_we, stall, wb_valid, e_addr, e_we);
            else n_pass++;
            if (st) begin
                n_chk++;
                if (mem_wdata !== model_wdata(f3, wd))
                    $display("FAIL %s wdata: got %h want %h", nm, mem_wdata, model_wdata(f3, wd));
                else n_pass++;
            end
            for (int i = 1; i <= lat; i++) begin
                // Upstream noise while in MEM must be ignored.
                req_valid = 1'b1; req_load = 1'($urandom); req_store = 1'($urandom);
                req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
                req_rd = 5'($urandom);
                mem_ready = (i == lat);
                mem_rdata = (i == lat) ? rdata : $urandom;
                @(posedge clk); #1;
                mem_ready = 1'b0;
                req_valid = 1'b0;
                mem_rdata = $urandom;
                if (i < lat) begin
                    n_chk++;
                    if (mem_en !== 1'b1 || mem_addr !== e_addr || mem_we !== e_we
                        || stall !== 1'b1 || wb_valid !== 1'b0)
                        $display("FAIL %s hold: got en=%0b a=%h we=%b st=%0b v=%0b",
                                 nm, mem_en, mem_addr, mem_we, stall, wb_valid);
                    else n_pass++;
                end
            end
            n_chk++;
            if (mem_en !== 1'b0 || wb_valid !== ld || lsu_err !== 1'b0)
                $display("FAIL %s done: got en=%0b v=%0b err=%0b want 0 %0b 0",
                         nm, mem_en, wb_valid, lsu_err, ld);
            else n_pass++;
            if (ld) begin
                n_chk++;
                if (wb_data !== e_load || wb_rd !== rd)
                    $display("FAIL %s load_data: got %h rd=%0d want %h rd=%0d",
                             nm, wb_data, wb_rd, e_load, rd);
                else n_pass++;
            end
            c_wb = wb_data;
        end
        @(posedge clk); #1;
        n_chk++;
        if (wb_valid !== 1'b0 || lsu_err !== 1'b0)
            $display("FAIL %s pulse_end: got v=%0b err=%0b want 0 0", nm, wb_valid, lsu_err);
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_funct3 = 3'h0; req_rd = 5'h0;
        mem_rdata = 32'h0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({stall, mem_en, mem_addr, mem_we, mem_wdata, wb_valid, wb_data, wb_rd, lsu_err}
            !== '0)
            $display("FAIL reset: got st=%0b en=%0b a=%h we=%b wd=%h v=%0b d=%h rd=%0d err=%0b",
                     stall, mem_en, mem_addr, mem_we, mem_wdata, wb_valid, wb_data, wb_rd,
                     lsu_err);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [31:0] ca, cwd, cwb;
        logic [3:0]  cwe;
        run_op("passthru", 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 32'h0, 1,
               ca, cwe, cwd, cwb);
        n_chk++;
        if (cwb !== 32'h0000_1234) $display("FAIL passthru_lit: got %h want 00001234", cwb);
        else n_pass++;
    endtask

    task automatic test_lb();
        logic [31:0] ca, cwd, cwb;
        logic [3:0]  cwe;
        run_op("lb", 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 32'h80FF_0000, 2,
               ca, cwe, cwd, cwb);
        n_chk++;
        if (ca !== 32'h0000_0100 || cwb !== 32'hFFFF_FF80)
            $display("FAIL lb_lit: got addr=%h data=%h want 00000100 ffffff80", ca, cwb);
        else n_pass++;
    endtask

    task automatic test_sh();
        logic [31:0] ca, cwd, cwb;
        logic [3:0]  cwe;
        run_op("sh", 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 5'd0, 32'h0, 3,
               ca, cwe, cwd, cwb);
        n_chk++;
        if (cwe !== 4'b1100 || cwd !== 32'hBEEF_BEEF)
            $display("FAIL sh_lit: got we=%b wdata=%h want 1100 beefbeef", cwe, cwd);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        logic [31:0] ca, cwd, cwb;
        logic [3:0]  cwe;
        run_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'h0, 5'd3, 32'h0, 1,
               ca, cwe, cwd, cwb);
        run_op("sb_ill", 1'b0, 1'b1, 3'b011, 32'h0000_0300, 32'h0, 5'd3, 32'h0, 1,
               ca, cwe, cwd, cwb);
    endtask

    task automatic test_lhu();
        logic [31:0] ca, cwd, cwb;
        logic [3:0]  cwe;
        run_op("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_0402, 32'h0, 5'd9, 32'h8001_0000, 1,
               ca, cwe, cwd, cwb);
        n_chk++;
        if (cwb !== 32'h0000_8001) $display("FAIL lhu_lit: got %h want 00008001", cwb);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] ca, cwd, cwb, a;
        logic [3:0]  cwe;
        int kind;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_op("rand", kind == 1, kind == 2, 3'($urandom), a, $urandom, 5'($urandom),
                   $urandom, $urandom_range(1, 3), ca, cwe, cwd, cwb);
        end
    endtask

    task automatic test_reset_mid_mem();
        req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h0000_0500; req_rd = 5'd11; req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_chk++;
        if (mem_en !== 1'b1) $display("FAIL rstmid_issue: got en=%0b want 1", mem_en);
        else n_pass++;
        #2 rst = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        n_chk++;
        if ({stall, mem_en, mem_addr, mem_we, mem_wdata, wb_valid, wb_data, wb_rd, lsu_err}
            !== '0)
            $display("FAIL rstmid_async: got st=%0b en=%0b a=%h we=%b wd=%h v=%0b d=%h err=%0b",
                     stall, mem_en, mem_addr, mem_we, mem_wdata, wb_valid, wb_data, lsu_err);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_chk++;
            if (wb_valid !== 1'b0 || mem_en !== 1'b0 || lsu_err !== 1'b0 || stall !== 1'b0)
                $display("FAIL rstmid_after%0d: got v=%0b en=%0b err=%0b st=%0b want 0 0 0 0",
                         i, wb_valid, mem_en, lsu_err, stall);
            else n_pass++;
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_lb();
        test_sh();
        test_misaligned();
        test_lhu();
        test_random();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clk input 1, sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst input 1, reset, asynchronous, active-high.
REQ-003 SHALL have ports: req_valid input 1, execute-stage request present this cycle.
REQ-004 SHALL have ports: req_addr input 32, effective address / ALU result from execute.
REQ-005 SHALL have ports: req_wdata input 32, store source (rs2).
REQ-006 SHALL have ports: req_funct3 input 3, access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-007 SHALL have ports: req_load input 1, req_store input 1, operation kind; neither = pass-through.
REQ-008 SHALL have ports: req_rd input 5, destination register.
REQ-009 SHALL have ports: stall output 1, upstream must hold request while high.
REQ-010 SHALL have ports: mem_en output 1, mem_addr output 32 (word-aligned, [1:0]=0), mem_we output 4, mem_wdata output 32, mem_rdata input 32, mem_ready input 1.
REQ-011 SHALL have ports: wb_valid output 1, wb_data output 32, wb_rd output 5, lsu_err output 1.

Function
REQ-012 SHALL implement FSM states IDLE, MEM; reset state IDLE.
REQ-013 SHALL, in IDLE with req_valid and neither op, register wb_data=req_addr, wb_rd=req_rd, pulse wb_valid next cycle (latency 1), stay IDLE.
REQ-014 SHALL flag misaligned when funct3 h/hu with addr[0]=1, or w with addr[1:0]!=0; illegal when funct3 in {011,110,111} for load/store.
REQ-015 SHALL, on misaligned/illegal load/store in IDLE, pulse lsu_err one cycle later, no memory access, no wb_valid, stay IDLE.
REQ-016 SHALL, on legal load/store in IDLE, register mem_addr={addr[31:2],2'b00}, mem_we, mem_wdata, rd, funct3, addr[1:0]; enter MEM.
REQ-017 SHALL hold mem_en=1 and mem_addr/mem_we/mem_wdata stable throughout MEM; mem_we=0 for loads.
REQ-018 SHALL build store mask: sb 0001<<addr[1:0]; sh 0011<<(2*addr[1]); sw 1111; mem_wdata = byte/half replicated across lanes.
REQ-019 SHALL, in MEM on mem_ready=1, return to IDLE, drop mem_en next cycle; for loads pulse wb_valid next cycle with extracted data.
REQ-020 SHALL extract load data: lane selected by addr[1:0]/addr[1]; b/h sign-extend, bu/hu zero-extend, w unchanged.
REQ-021 SHALL produce no wb_valid on store completion.
REQ-022 SHALL drive stall=1 in MEM, and in IDLE when req_valid with legal load/store; stall=0 otherwise (combinational).
REQ-023 SHALL ignore req_* while in MEM (upstream holds); mem_ready outside MEM ignored.
REQ-024 SHALL pulse wb_valid and lsu_err for exactly one cycle per accepted request; never both.

Reset
REQ-025 SHALL on rst, asynchronously force: state IDLE, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, wb_valid 0, wb_data 0, wb_rd 0, lsu_err 0.
REQ-026 SHALL abandon any in-flight MEM access on reset mid-operation; no late wb_valid after release.

Structure
REQ-027 SHALL place funct3 size codes, FSM state encoding and mask constants in shared package riscv_pkg.
REQ-028 SHALL instantiate one combinational sub-module lsu_load_align (rdata, addr[1:0], funct3 -> 32-bit extended data).

Verification
REQ-029 SHALL cover pass-through: req_addr=0x0000_1234, rd=5 -> next cycle wb_valid=1, wb_data=0x0000_1234, wb_rd=5, stall 0.
REQ-030 SHALL cover lb: addr=0x103, mem_rdata=0x80FF_0000, mem_ready after 2 MEM cycles -> mem_addr=0x100, wb_data=0xFFFF_FF80.
REQ-031 SHALL cover sh: addr=0x202, wdata=0xDEAD_BEEF -> mem_we=1100, mem_wdata=0xBEEF_BEEF, no wb_valid, stall high until mem_ready.
REQ-032 SHALL cover misaligned lw addr=0x301 -> lsu_err pulse, mem_en stays 0, wb_valid 0.
REQ-033 SHALL cover lhu addr=0x402, mem_rdata=0x8001_0000 -> wb_data=0x0000_8001.
REQ-034 SHALL cover rst asserted mid-MEM, then mem_ready -> all outputs 0, no wb_valid after release.
